quantum_timer: RTL and testbench
================================

# quantum_timer

Multi-channel preemption timer for the multitasking processor: holds one time quantum per process slot, counts down the quantum of the running slot on each non-held instruction clock, and raises a held interrupt with the expired slot number until the control unit acknowledges it. It replaces the single-quantum timer between the control unit and the context-switch logic. It adds per-slot quanta, an acknowledge handshake and optional hardware round-robin selection of the next slot.

## Interface
- WIDTH, 32, quantum and counter width in bits
- CHANNELS, 4, number of process slots (2..16)
- CH_W, 2, slot index width; must satisfy 2^CH_W >= CHANNELS
- ROUND_ROBIN, 1, 1 = on ack, automatically start the next slot with a nonzero quantum; 0 = go idle on ack

- clock  in  1  processor instruction clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- load  in  1  write `quantum` into slot `load_ch`
- load_ch  in  CH_W  slot written by `load`
- quantum  in  WIDTH  quantum value in instruction cycles
- start  in  1  arm slot `start_ch` and begin counting
- start_ch  in  CH_W  slot started by `start`
- hold  in  1  freeze the countdown this cycle (I/O wait, halt, LCD busy)
- finish  in  1  running process ended; disarm without interrupt
- ack  in  1  interrupt acknowledge from the control unit
- interrupt  out  1  quantum expired; held until ack/finish/start
- irq_ch  out  CH_W  slot whose quantum expired; valid while `interrupt`=1
- active  out  1  1 in RUN state
- active_ch  out  CH_W  slot currently or last selected
- remaining  out  WIDTH  current countdown value

## Operation
- Storage: CHANNELS quantum registers, WIDTH bits each; counter WIDTH bits; state register with IDLE, RUN, EXPIRED.
- `load` with `load_ch` < CHANNELS writes that slot in any state. An index >= CHANNELS is ignored. Loading the running slot does not change `remaining`; the new value applies at the next start of that slot.
- IDLE: outputs quiet.
  - `start` with a valid `start_ch`: counter <= quantum[start_ch], active_ch <= start_ch, then → RUN.
  - If that quantum is 0: → EXPIRED directly.
- RUN:
  - `hold`=0: counter decrements by 1.
  - If the counter is 1 and decrementing: counter <= 0, irq_ch <= active_ch, → EXPIRED.
  - `hold`=1: counter unchanged.
  - The counter never wraps below 0.
- EXPIRED: `interrupt`=1, counter stays 0.
  - `ack` with ROUND_ROBIN=0: → IDLE.
  - `ack` with ROUND_ROBIN=1: search slots active_ch+1, +2, … (mod CHANNELS, including active_ch last) for the first nonzero quantum. If found, load it and → RUN. If none, → IDLE.
- `finish` in RUN or EXPIRED: → IDLE, `interrupt` cleared, no new slot started.
- `start` in RUN or EXPIRED: preempts. The new slot is loaded exactly as from IDLE and any pending interrupt is cleared.
- Same-cycle priority: reset > finish > start > ack > countdown. `hold` is ignored outside RUN. `ack` outside EXPIRED is ignored.

## Timing
- Reset (async, active-low): state IDLE; interrupt=0, irq_ch=0, active=0, active_ch=0, remaining=0; all quanta 0.
- Start at edge t with quantum Q>0 and no hold: remaining=Q after t. `interrupt` rises after edge t+Q and is visible through the following cycle.
- Each held cycle in RUN delays expiry by one cycle.
- Quantum 0: `interrupt` is 1 after the start edge itself.
- `ack` seen at edge e clears `interrupt` after e. With ROUND_ROBIN=1, the next slot is in RUN after the same edge e, with remaining = that slot's quantum.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-RUN, with remaining=5 and interrupt pending on another run → all outputs 0 immediately, without waiting for a clock edge; quanta read back 0 (a start after reset expires at once).
- Load slot 2 = 4, start slot 2, no hold → interrupt=1, irq_ch=2 exactly 4 cycles after start; interrupt stays high 10 cycles until ack, then 0.
- Quantum 3 with hold pulsed high for 2 cycles mid-count → interrupt after 5 cycles; remaining frozen during the held cycles.
- ROUND_ROBIN=1, quanta {2,0,3,1}, start slot 0, ack each expiry → slot sequence 0,2,3,0 with counts 2,3,1,2. With all quanta then loaded 0, ack → IDLE, active=0.
- Same-cycle finish+ack in EXPIRED → IDLE, no new slot. Same-cycle start(slot 1)+ack → slot 1 running, interrupt 0.
- Load to the running slot (quantum 6 → 2) at remaining=4 → expiry still after 4 more cycles; the next start of that slot counts 2.

Source files
------------

// File: rtl/quantum_timer.sv
// quantum_timer: multi-slot preemption timer. Each process slot holds its own
// quantum; the running slot counts down on every non-held instruction clock and
// raises a held interrupt carrying the expired slot number until acknowledged.
// With ROUND_ROBIN=1 an acknowledge automatically starts the next slot that has
// a nonzero quantum.
module quantum_timer #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int CH_W        = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [WIDTH-1:0] quantum,
    input  logic             start,
    input  logic [CH_W-1:0]  start_ch,
    input  logic             hold,
    input  logic             finish,
    input  logic             ack,
    output logic             interrupt,
    output logic [CH_W-1:0]  irq_ch,
    output logic             active,
    output logic [CH_W-1:0]  active_ch,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    // One extra bit so CHANNELS itself is representable for range checks.
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [CH_W-1:0]  active_ch_q, active_ch_d;
    logic [CH_W-1:0]  irq_ch_q, irq_ch_d;
    logic [WIDTH-1:0] quanta_q [CHANNELS];
    logic [WIDTH-1:0] quanta_d [CHANNELS];

    logic             load_valid;
    logic             start_valid;
    logic             rr_found;
    logic [CH_W-1:0]  rr_ch;
    logic [CH_W-1:0]  rr_idx;

    assign load_valid  = load  && ({1'b0, load_ch}  < CH_LIMIT);
    assign start_valid = start && ({1'b0, start_ch} < CH_LIMIT);

    // Quantum table writes; a write never touches the live counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        quanta_d = quanta_q;
        if (load_valid) begin
            quanta_d[load_ch] = quantum;
        end
    end

    // Round-robin search: first nonzero quantum after the current slot,
    // wrapping around and visiting the current slot last.
    always_comb begin
        rr_found = 1'b0;
        rr_ch    = '0;
        rr_idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            rr_idx = CH_W'((int'(active_ch_q) + k) % CHANNELS);
            if (!rr_found && (quanta_q[rr_idx] != '0)) begin
                rr_found = 1'b1;
                rr_ch    = rr_idx;
            end
        end
    end

    // Next-state logic, priority finish > start > ack > countdown.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        active_ch_d = active_ch_q;
        irq_ch_d    = irq_ch_q;

        if ((state_q != S_IDLE) && finish) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (start_valid) begin
            count_d     = quanta_q[start_ch];
            active_ch_d = start_ch;
            if (quanta_q[start_ch] == '0) begin
                state_d  = S_EXPIRED;
                irq_ch_d = start_ch;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!hold) begin
                        // Count reaching zero expires; never wraps below 0.
                        if ((count_q == '0) || (count_q == WIDTH'(1))) begin
                            count_d  = '0;
                            irq_ch_d = active_ch_q;
                            state_d  = S_EXPIRED;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                S_EXPIRED: begin
                    count_d = '0;
                    if (ack) begin
                        if ((ROUND_ROBIN != 0) && rr_found) begin
                            count_d     = quanta_q[rr_ch];
                            active_ch_d = rr_ch;
                            state_d     = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter, slot registers and quantum table.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            active_ch_q <= '0;
            irq_ch_q    <= '0;
            // NOTE: the quantum table is a small register file that must read
            // back zero after reset, so it is reset like any other flop rather
            // than treated as an unreset RAM.
            for (int i = 0; i < CHANNELS; i++) begin
                quanta_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the values from before this edge.
            state_q     <= state_d;
            count_q     <= count_d;
            active_ch_q <= active_ch_d;
            irq_ch_q    <= irq_ch_d;
            quanta_q    <= quanta_d;
        end
    end

    assign interrupt = (state_q == S_EXPIRED);
    assign active    = (state_q == S_RUN);
    assign irq_ch    = irq_ch_q;
    assign active_ch = active_ch_q;
    assign remaining = count_q;

endmodule

// File: tb/tb_quantum_timer.sv
// Self-checking bench for quantum_timer: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run compared against a
// behavioural model of the slot timer.
module tb_quantum_timer;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             load;
    logic [CH_W-1:0]  load_ch;
    logic [WIDTH-1:0] quantum;
    logic             start;
    logic [CH_W-1:0]  start_ch;
    logic             hold;
    logic             finish;
    logic             ack;
    logic             interrupt;
    logic [CH_W-1:0]  irq_ch;
    logic             active;
    logic [CH_W-1:0]  active_ch;
    logic [WIDTH-1:0] remaining;

    int n_cmp  = 0;
    int n_fail = 0;

    quantum_timer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W), .ROUND_ROBIN(1)
    ) dut (
        .clock(clock), .reset(reset), .load(load), .load_ch(load_ch),
        .quantum(quantum), .start(start), .start_ch(start_ch), .hold(hold),
        .finish(finish), .ack(ack), .interrupt(interrupt), .irq_ch(irq_ch),
        .active(active), .active_ch(active_ch), .remaining(remaining)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             ld;
        logic [CH_W-1:0]  ldch;
        logic [WIDTH-1:0] q;
        logic             st;
        logic [CH_W-1:0]  stch;
        logic             h;
        logic             fin;
        logic             ak;
        logic             e_int;
        logic [CH_W-1:0]  e_irq;
        logic             e_act;
        logic [CH_W-1:0]  e_ach;
        logic [WIDTH-1:0] e_rem;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(int ld, int ldch, int q, int st, int stch,
                                int h, int fin, int ak, int ei, int eirq,
                                int ea, int each, int erem);
        vec_t v;
        v.ld    = ld[0];
        v.ldch  = ldch[CH_W-1:0];
        v.q     = q;
        v.st    = st[0];
        v.stch  = stch[CH_W-1:0];
        v.h     = h[0];
        v.fin   = fin[0];
        v.ak    = ak[0];
        v.e_int = ei[0];
        v.e_irq = eirq[CH_W-1:0];
        v.e_act = ea[0];
        v.e_ach = each[CH_W-1:0];
        v.e_rem = erem;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ei, input int eirq,
                              input int ea, input int each, input int erem);
        check({tag, ".interrupt"}, 32'(interrupt), ei);
        check({tag, ".irq_ch"},    32'(irq_ch),    eirq);
        check({tag, ".active"},    32'(active),    ea);
        check({tag, ".active_ch"}, 32'(active_ch), each);
        check({tag, ".remaining"}, remaining,      erem);
    endtask

    task automatic drive(input int ld, input int ldch, input int q,
                         input int st, input int stch, input int h,
                         input int fin, input int ak);
        load     = ld[0];
        load_ch  = ldch[CH_W-1:0];
        quantum  = q;
        start    = st[0];
        start_ch = stch[CH_W-1:0];
        hold     = h[0];
        finish   = fin[0];
        ack      = ak[0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic load_slot(input int ch, input int q);
        drive(1, ch, q, 0, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    // ---------------- behavioural reference model ----------------
    int m_q [CHANNELS];
    int m_mode;      // 0 idle, 1 counting, 2 interrupt pending
    int m_cnt;
    int m_ach;
    int m_irq;

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) m_q[i] = 0;
        m_mode = 0; m_cnt = 0; m_ach = 0; m_irq = 0;
    endtask

    task automatic model_step(input int ld, input int ldch, input int q,
                              input int st, input int stch, input int h,
                              input int fin, input int ak);
        int nxt;
        if (m_mode != 0 && fin != 0) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (st != 0) begin
            m_cnt = m_q[stch];
            m_ach = stch;
            if (m_cnt == 0) begin
                m_mode = 2;
                m_irq  = stch;
            end else begin
                m_mode = 1;
            end
        end else if (m_mode == 2) begin
            if (ak != 0) begin
                nxt = -1;
                for (int k = 1; k <= CHANNELS; k++) begin
                    if (nxt < 0 && m_q[(m_ach + k) % CHANNELS] != 0)
                        nxt = (m_ach + k) % CHANNELS;
                end
                if (nxt >= 0) begin
                    m_ach  = nxt;
                    m_cnt  = m_q[nxt];
                    m_mode = 1;
                end else begin
                    m_mode = 0;
                end
            end
        end else if (m_mode == 1 && h == 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_mode = 2;
                m_irq  = m_ach;
            end
        end
        if (ld != 0) m_q[ldch] = q;
    endtask

    // Slot/count expectations for the round-robin sequence.
    int rr_slot [4] = '{0, 2, 3, 0};
    int rr_cnt  [4] = '{2, 3, 1, 2};

    initial begin
        int n;
        int r_ld, r_ldch, r_q, r_st, r_stch, r_h, r_fin, r_ak;

        reset = 1'b1;
        idle();
        #3;

        // ---------------- reset state ----------------
        do_reset();
        check_outs("reset", 0, 0, 0, 0, 0);

        // ---------------- table-driven vectors ----------------
        vecs[0]  = mk(1, 2, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 1, 2, 4);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 3);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 2);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 2, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 2, 4);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 2, 0, 2, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 2, 0, 0, 1,  0, 0, 1, 2, 4);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 2, 4);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 2, 3);
        vecs[13] = mk(0, 0, 0, 1, 2, 0, 1, 0,  0, 0, 0, 2, 0);

        for (int i = 0; i < 14; i++) begin
            load = vecs[i].ld;   load_ch  = vecs[i].ldch; quantum = vecs[i].q;
            start = vecs[i].st;  start_ch = vecs[i].stch; hold    = vecs[i].h;
            finish = vecs[i].fin; ack = vecs[i].ak;
            tick();
            check_outs($sformatf("vec%0d", i), 32'(vecs[i].e_int),
                       32'(vecs[i].e_irq), 32'(vecs[i].e_act),
                       32'(vecs[i].e_ach), vecs[i].e_rem);
        end
        idle();

        // ---------------- expiry held until ack ----------------
        do_reset();
        load_slot(2, 4);
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        tick();
        idle();
        n = 0;
        while (!interrupt && n < 50) begin tick(); n++; end
        check("expire4.cycles", n, 4);
        check("expire4.irq_ch", 32'(irq_ch), 2);
        for (int i = 0; i < 10; i++) tick();
        check("expire4.held", 32'(interrupt), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);   // finish+ack: finish wins, no restart
        tick();
        idle();
        check_outs("finish_ack", 0, 2, 0, 2, 0);

        // ---------------- hold mid-count ----------------
        load_slot(1, 3);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        check("hold.r0", remaining, 3);
        idle(); tick();
        check("hold.r1", remaining, 2);
        hold = 1'b1; tick();
        check("hold.frozen1", remaining, 2);
        tick();
        check("hold.frozen2", remaining, 2);
        hold = 1'b0; tick();
        check("hold.r4", remaining, 1);
        check("hold.no_irq_yet", 32'(interrupt), 0);
        tick();
        check_outs("hold.expired", 1, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        idle();

        // ---------------- round robin sequence ----------------
        do_reset();
        load_slot(0, 2); load_slot(1, 0); load_slot(2, 3); load_slot(3, 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr%0d.slot", i), 32'(active_ch), rr_slot[i]);
            check($sformatf("rr%0d.count", i), remaining, rr_cnt[i]);
            n = 0;
            while (!interrupt && n < 50) begin tick(); n++; end
            check($sformatf("rr%0d.cycles", i), n, rr_cnt[i]);
            check($sformatf("rr%0d.irq_ch", i), 32'(irq_ch), rr_slot[i]);
            if (i < 3) begin
                ack = 1'b1; tick(); ack = 1'b0;
            end
        end
        for (int c = 0; c < CHANNELS; c++) load_slot(c, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        check("rr_none.active", 32'(active), 0);
        check("rr_none.interrupt", 32'(interrupt), 0);

        // ---------------- start+ack in EXPIRED: start wins ----------------
        load_slot(1, 2);
        load_slot(2, 7);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        tick(); idle(); tick(); tick();
        check("pre_start_ack.interrupt", 32'(interrupt), 1);
        drive(0, 0, 0, 1, 1, 0, 0, 1);
        tick();
        idle();
        check_outs("start_ack", 0, 1, 1, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        idle();

        // ---------------- load to running slot ----------------
        load_slot(0, 6);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        tick(); idle(); tick(); tick();
        check("reload.r4", remaining, 4);
        drive(1, 0, 2, 0, 0, 0, 0, 0);
        tick();
        idle();
        check("reload.unaffected", remaining, 3);
        n = 1;
        while (!interrupt && n < 50) begin tick(); n++; end
        check("reload.cycles", n, 4);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        idle();
        check("reload.next_start", remaining, 2);

        // ---------------- asynchronous reset mid-run ----------------
        load_slot(3, 9);
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        tick(); idle();
        for (int i = 0; i < 4; i++) tick();
        check("async.pre_rem", remaining, 5);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        @(posedge clock); #1;
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        tick();
        idle();
        check_outs("post_reset_start", 1, 3, 0, 3, 0);

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            r_ld   = ($urandom_range(0, 99) < 20) ? 1 : 0;
            r_ldch = $urandom_range(0, CHANNELS - 1);
            r_q    = $urandom_range(0, 6);
            r_st   = ($urandom_range(0, 99) < 8) ? 1 : 0;
            r_stch = $urandom_range(0, CHANNELS - 1);
            r_h    = ($urandom_range(0, 99) < 25) ? 1 : 0;
            r_fin  = ($urandom_range(0, 99) < 4) ? 1 : 0;
            r_ak   = ($urandom_range(0, 99) < 30) ? 1 : 0;
            drive(r_ld, r_ldch, r_q, r_st, r_stch, r_h, r_fin, r_ak);
            model_step(r_ld, r_ldch, r_q, r_st, r_stch, r_h, r_fin, r_ak);
            tick();
            check_outs($sformatf("rand%0d", cyc), (m_mode == 2) ? 1 : 0,
                       m_irq, (m_mode == 1) ? 1 : 0, m_ach, m_cnt);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
